// File: rtl/reaction_timer.sv
// Reaction-time core: random pre-GO delay, GO lamp, millisecond reaction count,
// with false-start and timeout detection. All outputs decode registered state.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | after reset, waiting for the first start
// S_WAIT    | counting down the random delay; stop here is a false start
// S_GO      | lamp on, counting ms until stop or MAX_MS
// S_DONE    | result valid in time_ms
// S_EARLY   | stop arrived before GO; time_ms = 0
// S_TIMEOUT | no stop within MAX_MS ticks; time_ms = MAX_MS
module reaction_timer #(
    parameter int DELAY_MIN_MS = 1000,
    parameter int RAND_BITS    = 10,
    parameter int MAX_MS       = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    output logic        led_go,
    output logic        busy,
    output logic        valid,
    output logic        early,
    output logic        timeout,
    output logic [13:0] time_ms,
    output logic [13:0] delay_ms
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_DONE,
        S_EARLY,
        S_TIMEOUT
    } state_t;

    localparam logic [13:0] DMIN    = 14'(DELAY_MIN_MS);
    localparam logic [13:0] MAXV    = 14'(MAX_MS);
    localparam logic [13:0] MAXV_M1 = 14'(MAX_MS - 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [13:0] dly_cnt_q, dly_cnt_d;
    logic [13:0] rx_cnt_q, rx_cnt_d;
    logic [13:0] time_q, time_d;
    logic [13:0] delay_q, delay_d;

    logic        lfsr_fb;
    logic [13:0] rand_ext;
    logic [13:0] delay_sum;

    // Right-shifting Fibonacci form of taps 16,14,13,11; a nonzero seed never reaches zero.
    assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign rand_ext  = {{(14 - RAND_BITS){1'b0}}, lfsr_q[RAND_BITS-1:0]};
    assign delay_sum = DMIN + rand_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= LFSR_SEED;
            dly_cnt_q <= '0;
            rx_cnt_q  <= '0;
            time_q    <= '0;
            delay_q   <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            dly_cnt_q <= dly_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            time_q    <= time_d;
            delay_q   <= delay_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = {lfsr_fb, lfsr_q[15:1]};
        dly_cnt_d = dly_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        time_d    = time_q;
        delay_d   = delay_q;

        case (state_q)
            S_IDLE, S_DONE, S_EARLY, S_TIMEOUT: begin
                if (start) begin
                    dly_cnt_d = delay_sum;
                    delay_d   = delay_sum;
                    time_d    = '0;
                    rx_cnt_d  = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    time_d  = '0;
                    state_d = S_EARLY;
                end else if (tick) begin
                    // <= 1 rather than == 1 keeps a zero delay from wrapping the counter
                    if (dly_cnt_q <= 14'd1) begin
                        rx_cnt_d = '0;
                        state_d  = S_GO;
                    end else begin
                        dly_cnt_d = dly_cnt_q - 14'd1;
                    end
                end
            end
            S_GO: begin
                if (stop) begin
                    time_d  = rx_cnt_q;
                    state_d = S_DONE;
                end else if (tick) begin
                    if (rx_cnt_q == MAXV_M1) begin
                        time_d  = MAXV;
                        state_d = S_TIMEOUT;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 14'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign led_go   = (state_q == S_GO);
    assign busy     = (state_q == S_WAIT) || (state_q == S_GO);
    assign valid    = (state_q == S_DONE);
    assign early    = (state_q == S_EARLY);
    assign timeout  = (state_q == S_TIMEOUT);
    assign time_ms  = time_q;
    assign delay_ms = delay_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with DELAY_MIN_MS=4, RAND_BITS=2, MAX_MS=20,
// one tick every 10 cycles; expected delays come from an independent LFSR model.
module tb_reaction_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        led_go, busy, valid, early, timeout;
    logic [13:0] time_ms, delay_ms;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] m_lfsr;
    logic [13:0] exp_d;

    reaction_timer #(
        .DELAY_MIN_MS(4),
        .RAND_BITS   (2),
        .MAX_MS      (20)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .start   (start),
        .stop    (stop),
        .led_go  (led_go),
        .busy    (busy),
        .valid   (valid),
        .early   (early),
        .timeout (timeout),
        .time_ms (time_ms),
        .delay_ms(delay_ms)
    );

    always #5 clk = ~clk;

    // Reference LFSR: seed ACE1 on reset, taps 16,14,13,11, shifting right.
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        repeat (9) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic start_round();
        exp_d = 14'd4 + {12'd0, m_lfsr[1:0]};
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || delay_ms !== exp_d || time_ms !== 14'd0 || led_go !== 1'b0) begin
            n_fail++;
            $display("FAIL start_round: busy=%b delay_ms=%0d time_ms=%0d led_go=%b, expected busy=1 delay_ms=%0d time_ms=0 led_go=0",
                     busy, delay_ms, time_ms, led_go, exp_d);
        end
    endtask

    task automatic run_delay();
        for (int i = 1; i <= int'(exp_d); i++) begin
            do_tick();
            n_tests++;
            if (i < int'(exp_d) && (led_go !== 1'b0 || busy !== 1'b1)) begin
                n_fail++;
                $display("FAIL wait_tick%0d: led_go=%b busy=%b, expected led_go=0 busy=1", i, led_go, busy);
            end else if (i == int'(exp_d) && (led_go !== 1'b1 || busy !== 1'b1)) begin
                n_fail++;
                $display("FAIL go_rise: led_go=%b busy=%b, expected led_go=1 busy=1", led_go, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({led_go, busy, valid, early, timeout} !== 5'b0 || time_ms !== 14'd0 || delay_ms !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_hold: flags=%b time_ms=%0d delay_ms=%0d, expected all 0",
                     {led_go, busy, valid, early, timeout}, time_ms, delay_ms);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if ({led_go, busy, valid, early, timeout} !== 5'b0 || time_ms !== 14'd0 || delay_ms !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_release: flags=%b time_ms=%0d delay_ms=%0d, expected all 0",
                     {led_go, busy, valid, early, timeout}, time_ms, delay_ms);
        end
        do_tick();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        n_tests++;
        if ({led_go, busy, valid, early, timeout} !== 5'b0 || time_ms !== 14'd0 || delay_ms !== 14'd0) begin
            n_fail++;
            $display("FAIL idle_ignore: flags=%b time_ms=%0d delay_ms=%0d, expected all 0",
                     {led_go, busy, valid, early, timeout}, time_ms, delay_ms);
        end
    endtask

    task automatic test_normal();
        start_round();
        run_delay();
        repeat (9) do_tick();
        n_tests++;
        if (led_go !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL go_hold: led_go=%b valid=%b, expected led_go=1 valid=0", led_go, valid);
        end
        repeat (3) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_tests++;
        if (valid !== 1'b1 || time_ms !== 14'd9 || led_go !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_done: valid=%b time_ms=%0d led_go=%b busy=%b, expected valid=1 time_ms=9 led_go=0 busy=0",
                     valid, time_ms, led_go, busy);
        end
    endtask

    task automatic test_false_start();
        start_round();
        repeat (2) do_tick();
        repeat (9) step();
        tick = 1'b1;
        stop = 1'b1;
        step();
        tick = 1'b0;
        stop = 1'b0;
        n_tests++;
        if (early !== 1'b1 || time_ms !== 14'd0 || led_go !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_flag: early=%b time_ms=%0d led_go=%b busy=%b valid=%b, expected early=1 time_ms=0 led_go=0 busy=0 valid=0",
                     early, time_ms, led_go, busy, valid);
        end
        for (int i = 0; i < 8; i++) begin
            do_tick();
            n_tests++;
            if (led_go !== 1'b0 || early !== 1'b1) begin
                n_fail++;
                $display("FAIL early_hold%0d: led_go=%b early=%b, expected led_go=0 early=1", i, led_go, early);
            end
        end
    endtask

    task automatic test_timeout();
        start_round();
        n_tests++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL early_clear: early=%b, expected 0", early);
        end
        run_delay();
        for (int i = 1; i <= 20; i++) begin
            do_tick();
            n_tests++;
            if (i < 20 && (led_go !== 1'b1 || timeout !== 1'b0)) begin
                n_fail++;
                $display("FAIL go_tick%0d: led_go=%b timeout=%b, expected led_go=1 timeout=0", i, led_go, timeout);
            end else if (i == 20 && (timeout !== 1'b1 || time_ms !== 14'd20 || busy !== 1'b0 || led_go !== 1'b0)) begin
                n_fail++;
                $display("FAIL timeout_flag: timeout=%b time_ms=%0d busy=%b led_go=%b, expected timeout=1 time_ms=20 busy=0 led_go=0",
                         timeout, time_ms, busy, led_go);
            end
        end
        repeat (3) do_tick();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_tests++;
        if (timeout !== 1'b1 || time_ms !== 14'd20) begin
            n_fail++;
            $display("FAIL timeout_hold: timeout=%b time_ms=%0d, expected timeout=1 time_ms=20", timeout, time_ms);
        end
    endtask

    task automatic test_coincide();
        start_round();
        n_tests++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: timeout=%b, expected 0", timeout);
        end
        do_tick();
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (delay_ms !== exp_d || busy !== 1'b1 || led_go !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_wait: delay_ms=%0d busy=%b led_go=%b, expected delay_ms=%0d busy=1 led_go=0",
                     delay_ms, busy, led_go, exp_d);
        end
        for (int i = 2; i <= int'(exp_d); i++) do_tick();
        n_tests++;
        if (led_go !== 1'b1) begin
            n_fail++;
            $display("FAIL go_after_restart_attempt: led_go=%b, expected 1", led_go);
        end
        repeat (2) do_tick();
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (led_go !== 1'b1 || busy !== 1'b1 || valid !== 1'b0 || delay_ms !== exp_d) begin
            n_fail++;
            $display("FAIL start_in_go: led_go=%b busy=%b valid=%b delay_ms=%0d, expected led_go=1 busy=1 valid=0 delay_ms=%0d",
                     led_go, busy, valid, delay_ms, exp_d);
        end
        repeat (3) do_tick();
        repeat (9) step();
        tick = 1'b1;
        stop = 1'b1;
        step();
        tick = 1'b0;
        stop = 1'b0;
        n_tests++;
        if (valid !== 1'b1 || time_ms !== 14'd5 || led_go !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_with_tick: valid=%b time_ms=%0d led_go=%b, expected valid=1 time_ms=5 led_go=0",
                     valid, time_ms, led_go);
        end
        repeat (4) step();
        start_round();
        n_tests++;
        if (valid !== 1'b0 || time_ms !== 14'd0) begin
            n_fail++;
            $display("FAIL start_in_done: valid=%b time_ms=%0d, expected valid=0 time_ms=0", valid, time_ms);
        end
    endtask

    task automatic test_reset_mid();
        run_delay();
        repeat (7) do_tick();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++;
        if ({led_go, busy, valid, early, timeout} !== 5'b0 || time_ms !== 14'd0 || delay_ms !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mid: flags=%b time_ms=%0d delay_ms=%0d, expected all 0",
                     {led_go, busy, valid, early, timeout}, time_ms, delay_ms);
        end
        step();
        start_round();
        run_delay();
        repeat (3) do_tick();
        repeat (2) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_tests++;
        if (valid !== 1'b1 || time_ms !== 14'd3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_round: valid=%b time_ms=%0d busy=%b, expected valid=1 time_ms=3 busy=0",
                     valid, time_ms, busy);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_false_start();
        test_timeout();
        test_coincide();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Reaction-time measurement core for the game datapath. It consumes the 1 ms strobe from the millisecond tick generator and runs one round per start press. Each round waits a pseudo-random delay, asserts the GO lamp, and counts milliseconds until the player presses stop. It flags false starts and timeouts, and its result feeds the seven-segment display logic.

## Interface
- DELAY_MIN_MS, default 1000: minimum pre-GO delay, in ticks.
- RAND_BITS, default 10: number of LFSR bits added to the delay (range 1..12).
  - Random span is 0..2^RAND_BITS-1.
  - Constraint: DELAY_MIN_MS + 2^RAND_BITS - 1 <= 16383.
- MAX_MS, default 9999: reaction count at which the round times out (<= 16383).
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; synchronous, active-low.
- tick  in  1  1 ms strobe; single-cycle, at least 2 cycles apart.
- start  in  1  debounced single-cycle start pulse.
- stop  in  1  debounced single-cycle stop pulse.
- led_go  out  1  GO lamp; high only in state GO.
- busy  out  1  high in WAIT or GO.
- valid  out  1  high in DONE; time_ms holds a valid result.
- early  out  1  high in EARLY (false start).
- timeout  out  1  high in TIMEOUT.
- time_ms  out  14  reaction time in ms; registered.
- delay_ms  out  14  delay loaded for the current round; registered, for display and verification.

## Operation
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Reset value 16'hACE1; advances every clock, including during reset release.
  - Never all-zero.
- States: IDLE, WAIT, GO, DONE, EARLY, TIMEOUT. Reset state is IDLE.
- IDLE, DONE, EARLY, TIMEOUT, on start:
  - Load dly_cnt and delay_ms with DELAY_MIN_MS + lfsr[RAND_BITS-1:0], using the LFSR value in the start cycle.
  - Clear time_ms and the reaction counter.
  - Go to WAIT.
  - stop is ignored in these states.
- WAIT:
  - stop → EARLY (takes priority over tick in the same cycle).
  - Otherwise, tick with dly_cnt==1 → GO, clear the reaction counter.
  - Otherwise, tick → dly_cnt−1.
  - start is ignored.
- GO:
  - stop → DONE, time_ms <= counter (a tick in the same cycle is not counted).
  - Otherwise, tick with counter==MAX_MS−1 → TIMEOUT, time_ms <= MAX_MS.
  - Otherwise, tick → counter+1.
  - start is ignored.
- EARLY: time_ms = 0.
- Widths: all counters are 14-bit unsigned. The delay sum is computed at 14 bits; no overflow under the parameter constraint.
- Outputs are decoded from the registered state, so there are no combinational paths from inputs to outputs.

## Timing
- Reset:
  - rst_n low at a clk edge gives, after that edge: state IDLE, lfsr 16'hACE1.
  - All outputs 0: led_go, busy, valid, early, timeout, time_ms, delay_ms.
  - Applies from any state, mid-round included; a partial count is discarded.
- start in cycle N: busy=1 and delay_ms valid at N+1.
- WAIT lasts exactly delay_ms ticks. led_go rises the cycle after the delay_ms-th tick.
- stop in cycle N:
  - From GO: valid=1 and time_ms final at N+1; led_go=0 at N+1.
  - From WAIT: early=1 at N+1.
- time_ms equals the number of ticks seen in GO strictly before the stop cycle. Range is 0..MAX_MS−1 for DONE, MAX_MS for TIMEOUT.
- Timeout: the MAX_MS-th tick in GO gives timeout=1 and led_go=0 on the next cycle.
- Result flags and time_ms hold until the next start or reset.

## Test plan
Parameters for all scenarios: DELAY_MIN_MS=4, RAND_BITS=2, MAX_MS=20; tick every 10 cycles.

1. Reset: hold rst_n=0 for 3 edges, release → all outputs 0, state IDLE. No output change on tick or stop while idle.
2. Normal round: start, then count delay_ms (4..7) ticks → led_go rises 1 cycle after the last delay tick. Stop after 9 more ticks → valid=1, time_ms=9, led_go=0.
3. False start: start, then stop before GO → early=1, time_ms=0, led_go never asserted. A tick coincident with stop does not enter GO.
4. Timeout: start and let GO run with no stop → after the 20th GO tick: timeout=1, time_ms=20, busy=0.
5. Edge coincidences:
   - Stop on the same cycle as a GO tick after 5 ticks → time_ms=5.
   - start during WAIT or GO → ignored.
   - start in DONE → new round; time_ms cleared, new delay_ms loaded.
6. Reset mid-GO after 7 ticks: rst_n low 1 edge → IDLE, all outputs 0. A following start begins a clean round.
